// File: rtl/alu_pkg.sv
// Shared EX-stage decode constants: ALUOp codes, R-type funct codes, ALU control
// opcodes and the HI/LO multiply/divide sequencer states.
package alu_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_RTYPE = 3'd2;
  localparam logic [2:0] ALUOP_ANDI  = 3'd3;
  localparam logic [2:0] ALUOP_ORI   = 3'd4;
  localparam logic [2:0] ALUOP_XORI  = 3'd5;
  localparam logic [2:0] ALUOP_SLTI  = 3'd6;
  localparam logic [2:0] ALUOP_SLTIU = 3'd7;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_SLL  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_NOR  = 4'd12
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  // True for any funct owned by the HI/LO unit.
  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                     FUNCT_MFHI, FUNCT_MFLO, FUNCT_MTHI, FUNCT_MTLO};
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative magnitude datapath: shift-add multiply / restoring divide on a shared
// 2*WIDTH accumulator, with combinational sign correction of the final result.
module muldiv_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_fix_c,
  output logic [WIDTH-1:0] lo_fix_c
);

  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [WIDTH-1:0]   opb, dvd_raw, a_mag, b_mag, quo, rem;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic               div_r, neg_q, neg_r, div_zero;

  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  // Mul: acc = {partial, multiplier}; Div: acc = {remainder, dividend->quotient}.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, opb};
    if (!div_r)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // Divide-by-zero bypasses the iteration result: all-ones quotient, raw dividend.
  always_comb begin
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!div_r) begin
      hi_fix_c = prod[2*WIDTH-1:WIDTH];
      lo_fix_c = prod[WIDTH-1:0];
    end else if (div_zero) begin
      hi_fix_c = dvd_raw;
      lo_fix_c = '1;
    end else begin
      hi_fix_c = rem;
      lo_fix_c = quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      opb      <= '0;
      dvd_raw  <= '0;
      div_r    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      div_r    <= is_div;
      neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r    <= is_signed && a[WIDTH-1];
      div_zero <= is_div && (b == '0);
      dvd_raw  <= a;
      opb      <= is_div ? b_mag : a_mag;
      acc      <= {WIDTH'(0), (is_div ? a_mag : b_mag)};
    end else if (step) begin
      acc <= acc_step;
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// HI/LO multiply/divide unit: decodes mul/div/move funct codes, sequences the
// iterative core, owns HI/LO and stalls the pipeline for its own ops while busy.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_fix_c, lo_fix_c;
  logic             md_sel, is_mul_div, is_div_op, is_signed_op, accept;

  always_comb begin
    md_sel       = op_valid && (alu_op == ALUOP_RTYPE);
    is_mul_div   = md_sel && (funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});
    is_div_op    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    is_signed_op = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    accept       = is_mul_div && !busy;
    stall        = busy && md_sel && is_muldiv_funct(funct);
    result_valid = !busy && md_sel && ((funct == FUNCT_MFHI) || (funct == FUNCT_MFLO));
    result       = '0;
    if (result_valid) result = (funct == FUNCT_MFHI) ? hi : lo;
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .step      (state == RUN),
    .is_div    (is_div_op),
    .is_signed (is_signed_op),
    .a         (rs_val),
    .b         (rt_val),
    .hi_fix_c  (hi_fix_c),
    .lo_fix_c  (lo_fix_c)
  );

  // Sequencer: WIDTH RUN cycles, then one FIX cycle that commits HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state <= RUN;
            cnt   <= CNT_W'(WIDTH - 1);
            busy  <= 1'b1;
          end else if (md_sel && (funct == FUNCT_MTHI)) begin
            hi <= rs_val;
          end else if (md_sel && (funct == FUNCT_MTLO)) begin
            lo <= rs_val;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state <= FIX;
            done  <= 1'b1;
          end
        end
        FIX: begin
          hi    <= hi_fix_c;
          lo    <= lo_fix_c;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: vector table with a HI/LO scoreboard,
// plus hand sequences for stall, move, and mid-operation reset behaviour.
module tb_alu_muldiv_unit;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic [2:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] rs_val, rt_val;
  logic         stall, busy, done, result_valid;
  logic [W-1:0] result, hi, lo;

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .alu_op       (alu_op),
    .funct        (funct),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .stall        (stall),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid = v;
    alu_op   = op;
    funct    = f;
    rs_val   = a;
    rt_val   = b;
  endtask

  // Present a mul/div op for one cycle (starting #1 after an edge) and record its result.
  task automatic issue_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    drive(1'b1, ALUOP_RTYPE, f, a, b);
    sb.push_back(e);
    @(posedge clk); #1;
    drive(1'b0, ALUOP_ADD, 6'h00, '0, '0);
  endtask

  // Wait for the done pulse (bounded), check latency, then compare HI/LO with the scoreboard.
  task automatic finish_op(input string name);
    exp_t e;
    int   cyc;
    logic busy_ok;
    cyc     = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= int'(W) + 8; k++) begin
      @(negedge clk);
      if (done) begin
        cyc = k;
        if (!busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    check({name, " done_cycle"}, W'(cyc), W'(W + 1));
    check({name, " busy_run"}, W'(busy_ok), W'(1));
    if (cyc == 0) begin
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    check({name, " hi"}, hi, e.hi);
    check({name, " lo"}, lo, e.lo);
    check({name, " done_end"}, W'(done), W'(0));
    check({name, " busy_end"}, W'(busy), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stall_ok;
    logic done_seen;
    exp_t e;

    vecs[0] = '{FUNCT_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{FUNCT_MULT,  32'hFFFFFFFC, 32'hFFFFFFFB, 32'h00000000, 32'h00000014};
    vecs[3] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{FUNCT_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
    vecs[5] = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{FUNCT_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[7] = '{FUNCT_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8] = '{FUNCT_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9] = '{FUNCT_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    rst_n = 1'b0;
    drive(1'b0, ALUOP_ADD, 6'h00, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset hi", hi, '0);
    check("reset lo", lo, '0);
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset stall", W'(stall), W'(0));
    check("reset result_valid", W'(result_valid), W'(0));
    check("reset result", result, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven mul/div vectors, issued back-to-back in the first IDLE cycle.
    for (int i = 0; i < 10; i++) begin
      issue_md(vecs[i].f, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);
      finish_op($sformatf("vec%0d", i));
    end

    // MULT 5*6, unrelated ADD flows, then MFLO is stalled through FIX.
    issue_md(FUNCT_MULT, 32'd5, 32'd6, 32'h0, 32'h1E);
    drive(1'b1, ALUOP_ADD, FUNCT_ADD, 32'd1, 32'd2);
    @(negedge clk);
    check("add_while_busy stall", W'(stall), W'(0));
    @(posedge clk); #1;
    drive(1'b1, ALUOP_RTYPE, FUNCT_ADD, 32'd1, 32'd2);
    @(negedge clk);
    check("rtype_add_while_busy stall", W'(stall), W'(0));
    @(posedge clk); #1;
    drive(1'b1, ALUOP_RTYPE, FUNCT_MFLO, '0, '0);
    stall_ok  = 1'b1;
    done_seen = 1'b0;
    for (int k = 3; k <= int'(W) + 8; k++) begin
      @(negedge clk);
      if (!stall || result_valid) stall_ok = 1'b0;
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("mflo stall_until_fix", W'(stall_ok), W'(1));
    check("mflo fix_reached", W'(done_seen), W'(1));
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("mult5x6 hi", hi, e.hi);
      check("mult5x6 lo", lo, e.lo);
    end
    @(negedge clk);
    check("mflo after_fix stall", W'(stall), W'(0));
    check("mflo after_fix valid", W'(result_valid), W'(1));
    check("mflo after_fix result", result, 32'h1E);
    @(posedge clk); #1;
    drive(1'b0, ALUOP_ADD, 6'h00, '0, '0);
    #1;
    check("idle result", result, '0);
    check("idle result_valid", W'(result_valid), W'(0));

    // MTHI / MTLO then read back with no stall.
    @(posedge clk); #1;
    drive(1'b1, ALUOP_RTYPE, FUNCT_MTHI, 32'hA5A5A5A5, '0);
    @(negedge clk);
    check("mthi stall", W'(stall), W'(0));
    @(posedge clk); #1;
    drive(1'b1, ALUOP_RTYPE, FUNCT_MFHI, '0, '0);
    @(negedge clk);
    check("mfhi stall", W'(stall), W'(0));
    check("mfhi valid", W'(result_valid), W'(1));
    check("mfhi result", result, 32'hA5A5A5A5);
    @(posedge clk); #1;
    drive(1'b1, ALUOP_RTYPE, FUNCT_MTLO, 32'h5A5A5A5A, '0);
    @(posedge clk); #1;
    drive(1'b1, ALUOP_RTYPE, FUNCT_MFLO, '0, '0);
    @(negedge clk);
    check("mflo result", result, 32'h5A5A5A5A);
    check("mthi_kept hi", hi, 32'hA5A5A5A5);
    @(posedge clk); #1;

    // Reset at cycle 10 of a DIV: no done pulse, HI/LO cleared.
    drive(1'b1, ALUOP_RTYPE, FUNCT_DIV, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(1'b0, ALUOP_ADD, 6'h00, '0, '0);
    repeat (9) @(posedge clk);
    #1;
    check("pre_reset busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("mid_reset busy", W'(busy), W'(0));
    check("mid_reset hi", hi, '0);
    check("mid_reset lo", lo, '0);
    done_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < int'(W) + 4; k++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    check("reset no_done", W'(done_seen), W'(0));
    sb.delete();
    @(posedge clk); #1;
    issue_md(FUNCT_MULT, 32'd123, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFF0A);
    finish_op("post_reset_mult");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
